// File: rtl/mem_stage_if.sv
// mem_stage_if
//   Bundles the LEGv8 EX/MEM inputs and the MEM/WB, branch and stall
//   outputs of the memory-access stage.
//   slave  : the stage itself (consumes *_In, drives *_Out)
//   master : whatever sits upstream/downstream (drives *_In, observes *_Out)
interface mem_stage_if;
  // EX/MEM side
  logic        RegWrite_In;
  logic        MemtoReg_In;
  logic        Branch_In;
  logic        MemRead_In;
  logic        MemWrite_In;
  logic        Zero_In;
  logic [63:0] ADD_result_In;
  logic [63:0] ALU_result_In;
  logic [63:0] rd_data_2_In;
  logic [4:0]  RegisterRd_In;
  // Branch resolution and upstream stall
  logic        PCSrc_Out;
  logic [63:0] Branch_Target_Out;
  logic        Stall_Out;
  // MEM/WB side
  logic        RegWrite_Out;
  logic        MemtoReg_Out;
  logic [63:0] Read_data_Out;
  logic [63:0] ALU_result_Out;
  logic [4:0]  RegisterRd_Out;
  logic        Misaligned_Out;

  modport slave (
    input  RegWrite_In, MemtoReg_In, Branch_In, MemRead_In, MemWrite_In,
           Zero_In, ADD_result_In, ALU_result_In, rd_data_2_In, RegisterRd_In,
    output PCSrc_Out, Branch_Target_Out, Stall_Out, RegWrite_Out, MemtoReg_Out,
           Read_data_Out, ALU_result_Out, RegisterRd_Out, Misaligned_Out
  );

  modport master (
    output RegWrite_In, MemtoReg_In, Branch_In, MemRead_In, MemWrite_In,
           Zero_In, ADD_result_In, ALU_result_In, rd_data_2_In, RegisterRd_In,
    input  PCSrc_Out, Branch_Target_Out, Stall_Out, RegWrite_Out, MemtoReg_Out,
           Read_data_Out, ALU_result_Out, RegisterRd_Out, Misaligned_Out
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage
//   LEGv8 memory-access stage. Holds the doubleword data memory, resolves
//   conditional branches and registers results into MEM/WB. Loads and stores
//   take MEM_LATENCY cycles (counted from the request cycle); upstream is
//   stalled for MEM_LATENCY-1 of them.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : mem_stage_if.slave (EX/MEM inputs, MEM/WB + branch + stall outputs)
//   MEM_DEPTH must be a power of 2 (>= 2); MEM_LATENCY must be >= 1.
module mem_stage #(
  parameter int MEM_DEPTH   = 128,
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  mem_stage_if.slave  bus
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int CNT_W = $clog2(MEM_LATENCY + 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  typedef struct packed {
    logic        regwrite;
    logic        memtoreg;
    logic [63:0] read_data;
    logic [63:0] alu_result;
    logic [4:0]  rd;
    logic        misaligned;
  } wb_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  wb_t                wb_q, wb_d;
  logic [63:0]        mem [MEM_DEPTH];

  logic [IDX_W-1:0]   idx;
  logic               mem_op;
  logic               misaligned;
  logic               load_only;
  logic               stall;
  logic               capture;   // MEM/WB takes the EX/MEM fields this edge
  logic               commit;    // access completes this edge
  logic               mem_we;

  // Upper address bits are ignored, so addresses wrap modulo MEM_DEPTH.
  assign idx        = bus.ALU_result_In[3 +: IDX_W];
  assign mem_op     = bus.MemRead_In | bus.MemWrite_In;
  assign misaligned = bus.ALU_result_In[2:0] != 3'b000;
  // A simultaneous read+write is a store only, so no load data is returned.
  assign load_only  = bus.MemRead_In & ~bus.MemWrite_In;
  assign mem_we     = commit & bus.MemWrite_In;

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    capture = 1'b0;
    commit  = 1'b0;
    wb_d    = '0;   // bubble unless overridden below

    unique case (state_q)
      IDLE: begin
        if (!mem_op) begin
          capture = 1'b1;
        end else if (misaligned) begin
          // Access is dropped; flag it downstream and suppress the write-back.
          wb_d.misaligned = 1'b1;
          wb_d.memtoreg   = bus.MemtoReg_In;
          wb_d.alu_result = bus.ALU_result_In;
          wb_d.rd         = bus.RegisterRd_In;
        end else if (MEM_LATENCY == 1) begin
          capture = 1'b1;
          commit  = 1'b1;
        end else begin
          stall   = 1'b1;
          cnt_d   = CNT_W'(MEM_LATENCY - 1);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        cnt_d = cnt_q - CNT_W'(1);
        // Counter value 1 marks the completion cycle; inputs are still held.
        if (cnt_q > CNT_W'(1)) begin
          stall = 1'b1;
        end else begin
          capture = 1'b1;
          commit  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (capture) begin
      wb_d.regwrite   = bus.RegWrite_In;
      wb_d.memtoreg   = bus.MemtoReg_In;
      wb_d.read_data  = load_only ? mem[idx] : 64'h0;
      wb_d.alu_result = bus.ALU_result_In;
      wb_d.rd         = bus.RegisterRd_In;
      wb_d.misaligned = 1'b0;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wb_q    <= wb_d;
    end
  end

  // NOTE: the data memory has no reset; contents survive reset, and a reset in
  // the completion cycle still blocks the pending store.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      mem[idx] <= bus.rd_data_2_In;
    end
  end

  assign bus.PCSrc_Out         = bus.Branch_In & bus.Zero_In;
  assign bus.Branch_Target_Out = bus.ADD_result_In;
  assign bus.Stall_Out         = stall;
  assign bus.RegWrite_Out      = wb_q.regwrite;
  assign bus.MemtoReg_Out      = wb_q.memtoreg;
  assign bus.Read_data_Out     = wb_q.read_data;
  assign bus.ALU_result_Out    = wb_q.alu_result;
  assign bus.RegisterRd_Out    = wb_q.rd;
  assign bus.Misaligned_Out    = wb_q.misaligned;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage
//   Three mem_stage instances with MEM_LATENCY = 1, 2, 3 share one stimulus
//   bundle; only the selected instance sees memory requests. A transaction-
//   level model (one doubleword array per instance) predicts MEM/WB contents.
module tb_mem_stage;

  localparam int DEPTH = 128;

  typedef struct packed {
    logic        regwrite;
    logic        memtoreg;
    logic [63:0] read_data;
    logic [63:0] alu_result;
    logic [4:0]  rd;
    logic        misaligned;
  } wb_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  int          sel = 2;          // selected instance == its latency
  int          vectors = 0;
  int          miscompares = 0;

  logic        in_regw = 0, in_m2r = 0, in_br = 0, in_rd = 0, in_wr = 0, in_zero = 0;
  logic [63:0] in_add = 0, in_alu = 0, in_data = 0;
  logic [4:0]  in_rdst = 0;

  logic [3:1]  stall_w;
  logic [3:1]  pcsrc_w;
  logic [63:0] tgt_w [1:3];
  wb_t         wb_w  [1:3];

  logic [63:0] model [1:3][DEPTH];

  always #5 clk = ~clk;

  for (genvar g = 1; g <= 3; g++) begin : g_dut
    mem_stage_if bus ();
    assign bus.RegWrite_In   = in_regw;
    assign bus.MemtoReg_In   = in_m2r;
    assign bus.Branch_In     = in_br;
    assign bus.MemRead_In    = in_rd && (sel == g);
    assign bus.MemWrite_In   = in_wr && (sel == g);
    assign bus.Zero_In       = in_zero;
    assign bus.ADD_result_In = in_add;
    assign bus.ALU_result_In = in_alu;
    assign bus.rd_data_2_In  = in_data;
    assign bus.RegisterRd_In = in_rdst;
    assign stall_w[g] = bus.Stall_Out;
    assign pcsrc_w[g] = bus.PCSrc_Out;
    assign tgt_w[g]   = bus.Branch_Target_Out;
    assign wb_w[g]    = {bus.RegWrite_Out, bus.MemtoReg_Out, bus.Read_data_Out,
                         bus.ALU_result_Out, bus.RegisterRd_Out, bus.Misaligned_Out};
    mem_stage #(.MEM_DEPTH(DEPTH), .MEM_LATENCY(g)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
    );
  end

  task automatic drive_nop();
    in_regw = 0; in_m2r = 0; in_br = 0; in_rd = 0; in_wr = 0; in_zero = 0;
    in_add = 0; in_alu = 0; in_data = 0; in_rdst = 0;
  endtask

  // One instruction through the stage on instance `sel`. Called at a negedge;
  // returns at the negedge after the result has been captured into MEM/WB.
  task automatic do_op(input bit rd, input bit wr, input logic [63:0] addr,
                       input logic [63:0] data, input bit regw, input bit m2r,
                       input logic [4:0] rdst);
    int          lat, idx, busy;
    bit          memop, mis, br, zr;
    logic [63:0] tgt;
    wb_t         exp;
    lat   = sel;
    memop = rd || wr;
    mis   = memop && ((addr % 8) != 0);
    idx   = int'((addr / 8) % DEPTH);
    br    = !memop && ($urandom_range(0, 1) == 1);
    zr    = $urandom_range(0, 1) == 1;
    tgt   = {$urandom, $urandom};
    in_regw = regw; in_m2r = m2r; in_br = br; in_rd = rd; in_wr = wr; in_zero = zr;
    in_add = tgt; in_alu = addr; in_data = data; in_rdst = rdst;
    #1;
    vectors++;
    if (stall_w[sel] !== (memop && !mis && lat > 1)) begin
      miscompares++;
      $display("FAIL request_stall lat%0d: got %b want %b", lat, stall_w[sel], memop && !mis && lat > 1);
    end
    vectors++;
    if ({pcsrc_w[sel], tgt_w[sel]} !== {br && zr, tgt}) begin
      miscompares++;
      $display("FAIL branch lat%0d: got %b/%h want %b/%h", lat, pcsrc_w[sel], tgt_w[sel], br && zr, tgt);
    end

    exp = '{regwrite: regw, memtoreg: m2r, read_data: 64'h0, alu_result: addr,
            rd: rdst, misaligned: 1'b0};
    if (memop && !mis) begin
      if (rd && !wr) exp.read_data = model[sel][idx];
      if (wr) model[sel][idx] = data;
    end

    busy = (memop && !mis) ? lat : 1;
    for (int k = 1; k < busy; k++) begin
      @(negedge clk); #1;
      vectors++;
      if (stall_w[sel] !== (lat - k > 1)) begin
        miscompares++;
        $display("FAIL access_stall lat%0d k%0d: got %b want %b", lat, k, stall_w[sel], lat - k > 1);
      end
      vectors++;
      if (wb_w[sel] !== wb_t'(0)) begin
        miscompares++;
        $display("FAIL bubble lat%0d k%0d: got %h want 0", lat, k, wb_w[sel]);
      end
    end

    @(negedge clk);
    vectors++;
    if (mis) begin
      if ({wb_w[sel].regwrite, wb_w[sel].read_data, wb_w[sel].misaligned} !== {1'b0, 64'h0, 1'b1}) begin
        miscompares++;
        $display("FAIL misaligned lat%0d: got rw=%b rd=%h mis=%b want rw=0 rd=0 mis=1",
                 lat, wb_w[sel].regwrite, wb_w[sel].read_data, wb_w[sel].misaligned);
      end
    end else if (wb_w[sel] !== exp) begin
      miscompares++;
      $display("FAIL result lat%0d addr=%h: got %h want %h", lat, addr, wb_w[sel], exp);
    end
  endtask

  task automatic test_reset();
    drive_nop();
    reset = 1;
    repeat (2) @(negedge clk);
    #1;
    for (int g = 1; g <= 3; g++) begin
      vectors++;
      if ({stall_w[g], wb_w[g]} !== '0) begin
        miscompares++;
        $display("FAIL reset_state lat%0d: got stall=%b wb=%h want 0", g, stall_w[g], wb_w[g]);
      end
    end
    reset = 0;
    sel = 2;
    do_op(0, 0, 64'h0, 64'h0, 0, 0, 5'd0);
  endtask

  task automatic test_fill();
    for (int g = 1; g <= 3; g++) begin
      sel = g;
      for (int i = 0; i < DEPTH; i++)
        do_op(0, 1, 64'(i * 8), {$urandom, $urandom}, 0, 0, 5'd0);
    end
  endtask

  task automatic test_store_load();
    sel = 2;
    do_op(0, 1, 64'h10, 64'hDEADBEEF_CAFEF00D, 0, 0, 5'd0);
    do_op(1, 0, 64'h10, 64'h0, 1, 1, 5'd9);
    vectors++;
    if ({wb_w[2].read_data, wb_w[2].regwrite, wb_w[2].rd} !== {64'hDEADBEEF_CAFEF00D, 1'b1, 5'd9}) begin
      miscompares++;
      $display("FAIL store_load: got %h/%b/%0d want deadbeefcafef00d/1/9",
               wb_w[2].read_data, wb_w[2].regwrite, wb_w[2].rd);
    end
  endtask

  task automatic test_misaligned();
    sel = 2;
    do_op(0, 1, 64'h0C, 64'h1111_2222_3333_4444, 1, 0, 5'd3);
    do_op(0, 0, 64'h1234, 64'h0, 1, 0, 5'd4);
    vectors++;
    if (wb_w[2].misaligned !== 1'b0) begin
      miscompares++;
      $display("FAIL misaligned_one_cycle: got %b want 0", wb_w[2].misaligned);
    end
    do_op(1, 0, 64'h08, 64'h0, 1, 1, 5'd1);
    do_op(1, 0, 64'h10, 64'h0, 1, 1, 5'd2);
    vectors++;
    if (wb_w[2].read_data !== 64'hDEADBEEF_CAFEF00D) begin
      miscompares++;
      $display("FAIL misaligned_untouched: got %h want deadbeefcafef00d", wb_w[2].read_data);
    end
  endtask

  task automatic test_wrap();
    sel = 2;
    do_op(0, 1, 64'h408, 64'h55, 0, 0, 5'd0);
    do_op(1, 0, 64'h008, 64'h0, 1, 1, 5'd7);
    vectors++;
    if (wb_w[2].read_data !== 64'h55) begin
      miscompares++;
      $display("FAIL wrap: got %h want 55", wb_w[2].read_data);
    end
  endtask

  task automatic test_branch();
    sel = 2;
    drive_nop();
    in_br = 1; in_zero = 1; in_add = 64'h200;
    #1;
    vectors++;
    if ({pcsrc_w[2], tgt_w[2]} !== {1'b1, 64'h200}) begin
      miscompares++;
      $display("FAIL branch_taken: got %b/%h want 1/200", pcsrc_w[2], tgt_w[2]);
    end
    in_zero = 0;
    #1;
    vectors++;
    if (pcsrc_w[2] !== 1'b0) begin
      miscompares++;
      $display("FAIL branch_not_taken: got %b want 0", pcsrc_w[2]);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    for (int g = 1; g <= 3; g++) begin
      sel = g;
      do_op(0, 1, 64'h40, 64'hA5A5_0000_0000_0001, 0, 0, 5'd0);
      do_op(1, 0, 64'h40, 64'h0, 1, 1, 5'd10);
      do_op(1, 1, 64'h48, 64'hA5A5_0000_0000_0002, 1, 0, 5'd11);
      do_op(1, 0, 64'h48, 64'h0, 1, 1, 5'd12);
    end
  endtask

  task automatic test_reset_abort();
    logic [63:0] old;
    sel = 3;
    old = model[3][4];
    in_regw = 0; in_m2r = 0; in_br = 0; in_rd = 0; in_wr = 1; in_zero = 0;
    in_add = 0; in_alu = 64'h20; in_data = 64'h77; in_rdst = 0;
    #1;
    vectors++;
    if (stall_w[3] !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_stall1: got %b want 1", stall_w[3]);
    end
    @(negedge clk); #1;
    vectors++;
    if (stall_w[3] !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_stall2: got %b want 1", stall_w[3]);
    end
    reset = 1;
    drive_nop();
    @(negedge clk); #1;
    vectors++;
    if ({stall_w[3], pcsrc_w[3], tgt_w[3], wb_w[3]} !== '0) begin
      miscompares++;
      $display("FAIL abort_outputs: got stall=%b pc=%b wb=%h want 0", stall_w[3], pcsrc_w[3], wb_w[3]);
    end
    reset = 0;
    @(negedge clk);
    do_op(1, 0, 64'h20, 64'h0, 1, 1, 5'd6);
    vectors++;
    if (wb_w[3].read_data !== old) begin
      miscompares++;
      $display("FAIL abort_no_commit: got %h want %h", wb_w[3].read_data, old);
    end
  endtask

  task automatic test_random();
    for (int g = 1; g <= 3; g++) begin
      sel = g;
      for (int n = 0; n < 120; n++) begin
        int          kind;
        logic [63:0] addr;
        kind = $urandom_range(0, 3);
        addr = {$urandom, $urandom};
        if ($urandom_range(0, 4) != 0) addr[2:0] = 3'b000;
        do_op(kind[0], kind[1], addr, {$urandom, $urandom}, $urandom_range(0, 1) == 1,
              $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)));
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_fill();
    test_store_load();
    test_misaligned();
    test_wrap();
    test_branch();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- LEGv8 memory-access stage. Sits directly downstream of the EX/MEM pipeline register and consumes its outputs.
- Contains the doubleword data memory and resolves conditional branches (PCSrc).
- Performs loads and stores with a parameterised multi-cycle latency. Stalls upstream while an access is in progress.
- Registers results into the MEM/WB boundary for write-back.

Parameters:
- MEM_DEPTH, default 128: number of 64-bit doublewords in data memory; must be a power of 2.
- MEM_LATENCY, default 2: cycles per load/store, counted from the request cycle; must be ≥1.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- RegWrite_In  in  1  register-write control from EX/MEM
- MemtoReg_In  in  1  write-back mux select from EX/MEM
- Branch_In  in  1  conditional-branch instruction
- MemRead_In  in  1  load request
- MemWrite_In  in  1  store request
- Zero_In  in  1  ALU zero flag
- ADD_result_In  in  64  branch target address
- ALU_result_In  in  64  memory byte address, or ALU result
- rd_data_2_In  in  64  store data
- RegisterRd_In  in  5  destination register
- PCSrc_Out  out  1  combinational: Branch_In & Zero_In
- Branch_Target_Out  out  64  combinational: equals ADD_result_In
- Stall_Out  out  1  combinational: upstream must hold EX/MEM and PC
- RegWrite_Out  out  1  MEM/WB register-write control
- MemtoReg_Out  out  1  MEM/WB write-back mux select
- Read_data_Out  out  64  MEM/WB load data
- ALU_result_Out  out  64  MEM/WB ALU result
- RegisterRd_Out  out  5  MEM/WB destination register
- Misaligned_Out  out  1  MEM/WB flag: misaligned access was dropped

Behaviour:
- Reset:
  - All registered outputs are 0; FSM goes to IDLE; latency counter is 0.
  - Memory contents are not cleared.
  - Reset during ACCESS aborts the access: a pending store is not committed and no load result is produced.
- Address:
  - Index is ALU_result_In[3 +: log2(MEM_DEPTH)]. Higher bits are ignored, so addresses wrap modulo MEM_DEPTH.
  - An access is misaligned when ALU_result_In[2:0] != 0.
- Request: a cycle with (MemRead_In | MemWrite_In) in IDLE, with a properly aligned address.
  - MemRead_In and MemWrite_In both high: treated as a store only; Read_data_Out = 0.
- States:
  - IDLE:
    - Non-memory instruction: no stall. MEM/WB captures at the next edge.
      - RegWrite_Out, MemtoReg_Out, ALU_result_Out and RegisterRd_Out take their _In values.
      - Read_data_Out = 0 and Misaligned_Out = 0.
    - Misaligned memory op: no access and no stall.
      - MEM/WB captures with RegWrite_Out = 0, Misaligned_Out = 1 and Read_data_Out = 0, for one cycle.
    - Request with MEM_LATENCY = 1: completes in the same cycle and Stall_Out = 0.
      - Store writes memory at the edge.
      - Load captures mem[index] into Read_data_Out at the edge.
    - Request with MEM_LATENCY > 1: Stall_Out = 1; counter is loaded with MEM_LATENCY - 1; go to ACCESS.
      - At this edge MEM/WB captures a bubble: all MEM/WB outputs are 0.
  - ACCESS:
    - Counter decrements every cycle.
    - Stall_Out = 1 while counter > 1.
      - Each of those cycles inserts a bubble into MEM/WB (RegWrite_Out = 0).
    - Counter == 1 is the completion cycle:
      - Stall_Out = 0.
      - At the edge the store commits, or the load data plus the EX/MEM fields are captured into MEM/WB.
      - Return to IDLE.
- Timing:
  - Total stall cycles per access = MEM_LATENCY - 1.
  - Result appears at the MEM/WB outputs MEM_LATENCY cycles after the request cycle's first edge.
  - Each store commits exactly once.
- Upstream obligations:
  - Inputs are held stable while Stall_Out = 1.
  - Inputs sampled in the completion cycle are the held values.
- Back-to-back: a new request in the cycle after completion starts immediately, with no idle gap.
- Branch: PCSrc_Out and Branch_Target_Out are purely combinational and independent of the FSM. Branches never assert MemRead/MemWrite.

Test Plan:
- Reset, then IDLE with no op (MEM_LATENCY = 2) → all MEM/WB outputs 0 and Stall_Out = 0.
- Store rd_data_2_In = 0xDEADBEEF_CAFEF00D to address 0x10, then load from 0x10 with RegisterRd_In = 9 →
  - Each op asserts Stall_Out for exactly 1 cycle.
  - The load gives Read_data_Out = 0xDEADBEEF_CAFEF00D, RegWrite_Out = 1 and RegisterRd_Out = 9, 2 cycles after the request.
- Store to 0x0C → no stall, Misaligned_Out = 1 and RegWrite_Out = 0 for one cycle; memory at 0x08 and 0x10 is unchanged.
- Store 0x55 to address 0x408 with MEM_DEPTH = 128 → a later load from 0x008 returns 0x55 (wrap).
- Branch_In = 1, Zero_In = 1, ADD_result_In = 0x200 → PCSrc_Out = 1 and Branch_Target_Out = 0x200 in the same cycle.
  - With Zero_In = 0 → PCSrc_Out = 0.
- Store 0x77 to 0x20 with MEM_LATENCY = 3, then assert reset in the 2nd stall cycle → after reset all outputs are 0; a load from 0x20 returns the old value, not 0x77.
